// File: rtl/decrypt_stream_pipe_if.sv
// Valid/ready stream bundle for decrypt_stream_pipe: input word side, result side and the transfer counter.
interface decrypt_stream_pipe_if #(
  parameter int KEY_W  = 11,
  parameter int DATA_W = 60,
  parameter int PAD_W  = 6,
  parameter int CNT_W  = 16
);
  localparam int IN_W = KEY_W + DATA_W + 1 + PAD_W;

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic              in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W:0]   out_data;
  logic              out_err;
  logic [CNT_W-1:0]  pkt_cnt;

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err, pkt_cnt
  );

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err, pkt_cnt
  );
endinterface

// File: rtl/decrypt_stream_pipe.sv
// Two-stage mask add/subtract stream pipe: S1 captures payload + expanded key mask, S2 computes
// the result into the output register. Full-throughput valid/ready with no comb in->out path.
module decrypt_stream_pipe #(
  parameter int              KEY_W   = 11,
  parameter int              DATA_W  = 60,
  parameter int              PAD_W   = 6,
  parameter int              NSEG    = 6,
  parameter logic [NSEG-1:0] INV_PAT = 6'b010110,
  parameter int              CNT_W   = 16
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  decrypt_stream_pipe_if.slave  bus
);
  localparam int IN_W   = KEY_W + DATA_W + 1 + PAD_W;
  localparam int MASK_W = NSEG * KEY_W;

  // field split and key expansion
  logic [KEY_W-1:0]  key;
  logic [DATA_W:0]   y;
  logic [MASK_W-1:0] mask_full;
  logic              unused_bits;

  assign key = bus.in_data[IN_W-1 -: KEY_W];
  assign y   = bus.in_data[PAD_W +: DATA_W+1];

  for (genvar i = 0; i < NSEG; i++) begin : g_seg
    assign mask_full[i*KEY_W +: KEY_W] = INV_PAT[i] ? ~key : key;
  end

  assign unused_bits = ^{mask_full[MASK_W-1:DATA_W], bus.in_data[PAD_W-1:0]};

  // vld_pipe_q[1] = S1 holding register, vld_pipe_q[2] = output register
  logic [2:1]        vld_pipe_q, vld_pipe_d;
  logic [DATA_W:0]   s1_y_q, s1_y_d;
  logic [DATA_W-1:0] s1_b_q, s1_b_d;
  logic              s1_mode_q, s1_mode_d;
  logic [DATA_W:0]   out_data_q, out_data_d;
  logic              out_err_q, out_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic s2_adv, in_rdy, accept;
  assign s2_adv = ~vld_pipe_q[2] | bus.out_ready;
  assign in_rdy = ~vld_pipe_q[1] | s2_adv;
  assign accept = bus.in_valid & in_rdy;

  // one extra bit on top catches carry (encrypt) and borrow (decrypt)
  logic [DATA_W+1:0] sum_w, diff_w;
  logic [DATA_W:0]   res_data;
  logic              res_err;

  assign sum_w    = {1'b0, s1_y_q} + {2'b00, s1_b_q};
  assign diff_w   = {1'b0, s1_y_q} - {2'b00, s1_b_q};
  assign res_data = s1_mode_q ? sum_w[DATA_W:0] : diff_w[DATA_W:0];
  assign res_err  = s1_mode_q ? sum_w[DATA_W+1] : (diff_w[DATA_W+1] | diff_w[DATA_W]);

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_y_d     = s1_y_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    cnt_d      = cnt_q;

    if (in_rdy) begin
      vld_pipe_d[1] = bus.in_valid;
      if (accept) begin
        s1_y_d    = y;
        s1_b_d    = mask_full[DATA_W-1:0];
        s1_mode_d = bus.in_mode;
      end
    end

    // output register only reloads when it can advance, so a stalled result stays put
    if (s2_adv) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      if (vld_pipe_q[1]) begin
        out_data_d = res_data;
        out_err_d  = res_err;
      end
    end

    if (vld_pipe_q[2] & bus.out_ready)
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vld_pipe_q <= '0;
      s1_y_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= 1'b0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_y_q     <= s1_y_d;
      s1_b_q     <= s1_b_d;
      s1_mode_q  <= s1_mode_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_pipe_q[2];
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;
  assign bus.pkt_cnt   = cnt_q;
endmodule
